// File: rtl/minefield_generator_pkg.sv
// Shared definitions for the minefield generator and the solver that consumes it:
// default board geometry, count width, FSM encoding, response layout and the
// LFSR step function.
package minefield_generator_pkg;

  localparam int          ROWS_DEF  = 8;
  localparam int          COLS_DEF  = 8;
  localparam int          MINES_DEF = 10;
  localparam logic [15:0] SEED_DEF  = 16'hACE1;
  localparam int          COUNT_W   = 4;

  // Galois right-shift form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {IDLE, PLACE, COUNT, SERVE} state_t;

  typedef struct packed {
    logic               err;
    logic               mine;
    logic [COUNT_W-1:0] count;
  } rsp_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/minefield_generator_lfsr16.sv
// 16-bit Galois LFSR used to pick mine candidates.
//   clk, reset (async, active-low) ; load : q := seed (wins over step)
//   step : advance one state ; seed : load value ; q : low Q_W bits of the state
module lfsr16 import minefield_generator_pkg::*; #(
  parameter int Q_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic [15:0]    seed,
  output logic [Q_W-1:0] q
);

  logic [15:0] st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    st <= '0;
    else if (load) st <= seed;
    else if (step) st <= lfsr_next(st);
  end

  assign q = st[Q_W-1:0];

endmodule

// File: rtl/minefield_generator.sv
// Builds a pseudo-random ROWS x COLS minefield, precomputes per-cell neighbour
// counts, then answers (row,col) reveal requests for the solver.
//   clk, reset (async, active-low)
//   gen                          : (re)build the board from SEED, any state
//   busy / ready                 : building (PLACE/COUNT) / serving (SERVE)
//   req_valid/req_ready/row/col  : reveal request, one in flight
//   rsp_valid/mine/count/err     : one-cycle response pulse after accept
module minefield_generator import minefield_generator_pkg::*; #(
  parameter int          ROWS  = ROWS_DEF,
  parameter int          COLS  = COLS_DEF,
  parameter int          MINES = MINES_DEF,
  parameter logic [15:0] SEED  = SEED_DEF,
  localparam int         RW    = $clog2(ROWS),
  localparam int         CW    = $clog2(COLS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               gen,
  output logic               busy,
  output logic               ready,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [RW-1:0]      req_row,
  input  logic [CW-1:0]      req_col,
  output logic               rsp_valid,
  output logic               rsp_mine,
  output logic [COUNT_W-1:0] rsp_count,
  output logic               rsp_err
);

  localparam int N      = ROWS * COLS;
  localparam int IDXW   = $clog2(N);
  localparam int LAST   = N - 1;
  localparam int COL_LS = COLS - 1;

  localparam logic [IDXW:0]   N_L     = N[IDXW:0];
  localparam logic [IDXW-1:0] MINES_L = MINES[IDXW-1:0];
  localparam logic [IDXW-1:0] LAST_L  = LAST[IDXW-1:0];
  localparam logic [IDXW-1:0] COLS_I  = COLS[IDXW-1:0];
  localparam logic [RW:0]     ROWS_L  = ROWS[RW:0];
  localparam logic [CW:0]     COLS_L  = COLS[CW:0];
  localparam logic [CW-1:0]   COL_LST = COL_LS[CW-1:0];

  state_t             state, state_nxt;
  logic               lfsr_load, lfsr_step, accept;
  logic [IDXW-1:0]    cand;
  logic               cand_ok;
  logic [N-1:0]       mine;
  logic [COUNT_W-1:0] cnt [0:N-1];
  logic [IDXW-1:0]    placed, cidx;
  logic [RW-1:0]      crow;
  logic [CW-1:0]      ccol;
  logic [COUNT_W-1:0] nsum;
  int                 nr, nc;
  logic               req_err;
  logic [IDXW-1:0]    req_idx;
  rsp_t               rsp_q;

  lfsr16 #(.Q_W(IDXW)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (SEED),
    .q     (cand)
  );

  // Candidates past the board (non power-of-two N) or on an existing mine are skipped.
  assign cand_ok = ({1'b0, cand} < N_L) && !mine[cand];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state)
      PLACE: begin
        lfsr_step = 1'b1;
        if (placed == MINES_L) state_nxt = COUNT;
      end
      COUNT:   if (cidx == LAST_L) state_nxt = SERVE;
      SERVE:   ;
      default: ;
    endcase
    // gen restarts the build from any state and pre-empts a same-cycle request.
    if (gen) begin
      state_nxt = PLACE;
      lfsr_load = 1'b1;
    end
    busy      = (state == PLACE) || (state == COUNT);
    ready     = (state == SERVE);
    req_ready = ready && !rsp_valid;
    accept    = req_valid && req_ready && !gen;
  end

  // Neighbour sum for the cell being counted; off-board neighbours add nothing.
  always_comb begin
    nsum = '0;
    nr   = 0;
    nc   = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        nr = int'(crow) + dr;
        nc = int'(ccol) + dc;
        if (!(dr == 0 && dc == 0) && nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS)
          nsum = nsum + COUNT_W'(mine[IDXW'(nr * COLS + nc)]);
      end
    end
  end

  assign req_err = ({1'b0, req_row} >= ROWS_L) || ({1'b0, req_col} >= COLS_L);
  assign req_idx = IDXW'(req_row) * COLS_I + IDXW'(req_col);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mine      <= '0;
      placed    <= '0;
      cidx      <= '0;
      crow      <= '0;
      ccol      <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_q.err   <= req_err;
        rsp_q.mine  <= !req_err && mine[req_idx];
        rsp_q.count <= req_err ? '0 : cnt[req_idx];
      end
      if (gen) begin
        mine   <= '0;
        placed <= '0;
        cidx   <= '0;
        crow   <= '0;
        ccol   <= '0;
      end else begin
        case (state)
          PLACE: if (placed != MINES_L && cand_ok) begin
            mine[cand] <= 1'b1;
            placed     <= placed + 1'b1;
          end
          COUNT: begin
            cnt[cidx] <= mine[cidx] ? '0 : nsum;
            if (cidx != LAST_L) begin
              cidx <= cidx + 1'b1;
              if (ccol == COL_LST) begin
                ccol <= '0;
                crow <= crow + 1'b1;
              end else begin
                ccol <= ccol + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rsp_mine  = rsp_q.mine;
  assign rsp_count = rsp_q.count;
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_minefield_generator.sv
// Directed bench: 8x8/10-mine main instance, 8x8/0-mine instance and a 6x6
// instance whose 3-bit request fields can address off-board cells.
module tb_minefield_generator;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       gen = 1'b0, req_valid = 1'b0;
  logic [2:0] req_row = '0, req_col = '0;
  logic       busy, ready, req_ready, rsp_valid, rsp_mine, rsp_err;
  logic [3:0] rsp_count;

  logic       gen2 = 1'b0, rv2 = 1'b0;
  logic [2:0] rr2 = '0, rc2 = '0;
  logic       z_busy, z_ready, z_req_ready, z_rsp_valid, z_rsp_mine, z_rsp_err;
  logic [3:0] z_rsp_count;
  logic       e_busy, e_ready, e_req_ready, e_rsp_valid, e_rsp_mine, e_rsp_err;
  logic [3:0] e_rsp_count;

  int total = 0, bad = 0;

  logic [63:0] m_mine;
  logic [3:0]  m_cnt [64];
  int          m_place;

  always #5 clk = ~clk;

  minefield_generator #(.ROWS(8), .COLS(8), .MINES(10), .SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .gen(gen), .busy(busy), .ready(ready),
    .req_valid(req_valid), .req_ready(req_ready), .req_row(req_row), .req_col(req_col),
    .rsp_valid(rsp_valid), .rsp_mine(rsp_mine), .rsp_count(rsp_count), .rsp_err(rsp_err));

  minefield_generator #(.ROWS(8), .COLS(8), .MINES(0), .SEED(16'hACE1)) dz (
    .clk(clk), .reset(reset), .gen(gen2), .busy(z_busy), .ready(z_ready),
    .req_valid(rv2), .req_ready(z_req_ready), .req_row(rr2), .req_col(rc2),
    .rsp_valid(z_rsp_valid), .rsp_mine(z_rsp_mine), .rsp_count(z_rsp_count), .rsp_err(z_rsp_err));

  minefield_generator #(.ROWS(6), .COLS(6), .MINES(4), .SEED(16'hACE1)) de (
    .clk(clk), .reset(reset), .gen(gen2), .busy(e_busy), .ready(e_ready),
    .req_valid(rv2), .req_ready(e_req_ready), .req_row(rr2), .req_col(rc2),
    .rsp_valid(e_rsp_valid), .rsp_mine(e_rsp_mine), .rsp_count(e_rsp_count), .rsp_err(e_rsp_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference board: Galois x^16+x^14+x^13+x^11+1 from 0xACE1, 6-bit candidates.
  task automatic build_model();
    logic [15:0] q;
    int placed, tries;
    q = 16'hACE1; placed = 0; tries = 0; m_mine = '0;
    while (placed < 10 && tries < 100000) begin
      if (!m_mine[q[5:0]]) begin
        m_mine[q[5:0]] = 1'b1;
        placed++;
      end
      tries++;
      q = {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
    end
    m_place = tries + 1;  // one extra PLACE cycle sees placed == MINES
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        int s;
        s = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
              s += int'(m_mine[(r + dr) * 8 + c + dc]);
        m_cnt[r * 8 + c] = m_mine[r * 8 + c] ? 4'd0 : 4'(s);
      end
  endtask

  task automatic req(input int r, input int c, output logic om);
    @(negedge clk);
    req_valid = 1'b1; req_row = 3'(r); req_col = 3'(c);
    chk($sformatf("req_ready_%0d_%0d", r, c), req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    om = rsp_mine;
    chk($sformatf("rsp_valid_%0d_%0d", r, c), rsp_valid, 1);
    chk($sformatf("mine_%0d_%0d", r, c), rsp_mine, m_mine[r * 8 + c]);
    chk($sformatf("count_%0d_%0d", r, c), rsp_count, m_cnt[r * 8 + c]);
    chk($sformatf("err_%0d_%0d", r, c), rsp_err, 0);
    @(negedge clk);
    chk($sformatf("rsp_drop_%0d_%0d", r, c), rsp_valid, 0);
  endtask

  task automatic sweep(input string tag);
    int n;
    logic m;
    n = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        req(r, c, m);
        if (m === 1'b1) n++;
      end
    chk({tag, "_mine_total"}, n, 10);
  endtask

  task automatic wait_ready(input string tag, input int exp_k);
    int k;
    k = 0;
    while (ready !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, k, exp_k);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic req2(input int r, input int c, input logic ee);
    @(negedge clk);
    rv2 = 1'b1; rr2 = 3'(r); rc2 = 3'(c);
    chk($sformatf("e_req_ready_%0d_%0d", r, c), e_req_ready, 1);
    @(negedge clk);
    rv2 = 1'b0;
    chk($sformatf("e_valid_%0d_%0d", r, c), e_rsp_valid, 1);
    chk($sformatf("e_err_%0d_%0d", r, c), e_rsp_err, ee);
    if (ee) begin
      chk($sformatf("e_mine_%0d_%0d", r, c), e_rsp_mine, 0);
      chk($sformatf("e_count_%0d_%0d", r, c), e_rsp_count, 0);
    end
    @(negedge clk);
  endtask

  initial begin
    logic m;
    int k;
    build_model();

    // 1: reset
    repeat (5) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_ready", ready, 0);
    chk("idle_req_ready", req_ready, 0);
    chk("idle_rsp_valid", rsp_valid, 0);

    // 2: build, exact latency, full sweep
    gen = 1'b1;
    @(negedge clk);
    gen = 1'b0;
    chk("gen_busy", busy, 1);
    chk("gen_ready", ready, 0);
    wait_ready("build_latency", m_place + 64);
    sweep("sweep1");

    // 3: corners and interior
    req(0, 0, m);
    req(7, 7, m);
    req(3, 4, m);

    // 4: back-to-back requests alternate req_ready
    @(negedge clk);
    req_valid = 1'b1; req_row = 3'd3; req_col = 3'd4;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("b2b_ready%0d", i), req_ready, (i % 2 == 0));
      chk($sformatf("b2b_valid%0d", i), rsp_valid, (i % 2 == 1));
      if (i % 2 == 1) chk($sformatf("b2b_count%0d", i), rsp_count, m_cnt[28]);
      @(negedge clk);
    end
    req_valid = 1'b0;
    @(negedge clk);

    // MINES=0 build latency and all-zero board; 6x6 out-of-range requests
    gen2 = 1'b1;
    @(negedge clk);
    gen2 = 1'b0;
    chk("z_gen_busy", z_busy, 1);
    k = 0;
    while (z_ready !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("z_latency", k, 65);
    k = 0;
    while (e_ready !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("e_ready", e_ready, 1);
    chk("e_busy", e_busy, 0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        rv2 = 1'b1; rr2 = 3'(r); rc2 = 3'(c);
        @(negedge clk);
        rv2 = 1'b0;
        chk($sformatf("z_cell_%0d_%0d", r, c),
            {z_rsp_valid, z_rsp_mine, z_rsp_err, z_rsp_count}, 7'b1000000);
        @(negedge clk);
      end
    chk("z_req_ready", z_req_ready, 1);
    req2(6, 2, 1'b1);
    req2(2, 7, 1'b1);
    req2(7, 7, 1'b1);
    req2(5, 5, 1'b0);

    // 5: gen mid-COUNT, then gen colliding with an accepted request
    @(negedge clk);
    gen = 1'b1;
    @(negedge clk);
    gen = 1'b0;
    repeat (m_place + 10) @(negedge clk);
    chk("midcount_busy", busy, 1);
    gen = 1'b1;
    @(negedge clk);
    gen = 1'b0;
    wait_ready("rebuild_latency", m_place + 64);
    sweep("sweep2");
    @(negedge clk);
    req_valid = 1'b1; req_row = 3'd3; req_col = 3'd4;
    chk("collide_req_ready", req_ready, 1);
    gen = 1'b1;
    @(negedge clk);
    gen = 1'b0; req_valid = 1'b0;
    chk("collide_no_rsp", rsp_valid, 0);
    chk("collide_busy", busy, 1);
    @(negedge clk);
    chk("collide_no_rsp2", rsp_valid, 0);
    wait_ready("collide_latency", m_place + 63);
    sweep("sweep3");

    // 6: async reset during PLACE
    @(negedge clk);
    gen = 1'b1;
    @(negedge clk);
    gen = 1'b0;
    @(negedge clk);
    chk("place_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("areset_outs", {busy, ready, req_ready, rsp_valid}, 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", {busy, ready, req_ready, rsp_valid}, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
